// File: rtl/fan_tach_pkg.sv
// ----------------------------------------------------------------------------
// fan_tach_pkg
// Shared constants and helpers for the fan tachometer front end.
//   CNT_W         : width of the per-window falling-edge count
//   MM_CLK_1S_CNT : window terminal count for 1 s at 50 MHz
//   FILT_W        : width of the glitch-filter mismatch counter (FILT_LEN 1..15)
//   sat_inc_cnt() : saturating increment for the edge count
// ----------------------------------------------------------------------------
package fan_tach_pkg;

  localparam int CNT_W  = 27;
  localparam int FILT_W = 4;

  localparam logic [CNT_W-1:0] MM_CLK_1S_CNT = 27'h2FAF07F;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fan_tach_ch.sv
// ----------------------------------------------------------------------------
// fan_tach_ch
// One tachometer channel: 2-FF synchroniser, glitch filter, falling-edge
// detect, per-window edge accumulator and edge-to-edge period counter.
// Ports:
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   fan_in       : raw tach pin (asynchronous, idle high)
//   fan_en       : channel enable; when low the channel reports nothing
//   clr          : synchronous clear of accumulators (outputs hold)
//   close        : window close strobe from the top (already excludes clr)
//   cnt          : falling edges in the last completed window
//   per          : CLK_I cycles between the last two accepted falling edges
//   stall        : last completed window had no edges while enabled
// ----------------------------------------------------------------------------
module fan_tach_ch
  import fan_tach_pkg::*;
#(
  parameter int FILT_LEN = 4,
  parameter int PER_W    = 24
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             fan_in,
  input  logic             fan_en,
  input  logic             clr,
  input  logic             close,
  output logic [CNT_W-1:0] cnt,
  output logic [PER_W-1:0] per,
  output logic             stall
);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

  logic              sync_1_q, sync_2_q;
  logic              filt_q, prev_q;
  logic [FILT_W-1:0] mcnt_q;
  logic              edge_fall;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [CNT_W-1:0]  closing;
  logic [PER_W-1:0]  per_cnt_q;
  logic              first_seen_q;

  // Synchroniser resets to the idle-high level so reset release never looks
  // like a falling edge.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, regardless of block order.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sync_1_q <= 1'b1;
      sync_2_q <= 1'b1;
    end else begin
      sync_1_q <= fan_in;
      sync_2_q <= sync_1_q;
    end
  end

  // A level change is accepted only after FILT_LEN consecutive mismatching
  // cycles; any return to agreement restarts the count.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      mcnt_q <= '0;
    end else begin
      prev_q <= filt_q;
      if (sync_2_q != filt_q) begin
        if (mcnt_q == FILT_LAST) begin
          filt_q <= sync_2_q;
          mcnt_q <= '0;
        end else begin
          mcnt_q <= mcnt_q + FILT_W'(1);
        end
      end else begin
        mcnt_q <= '0;
      end
    end
  end

  // Filter keeps running while disabled; only the edge is suppressed.
  assign edge_fall = prev_q & ~filt_q & fan_en;

  // Count including an edge landing in the close cycle itself.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    closing = edge_cnt_q;
    if (edge_fall) closing = sat_inc_cnt(edge_cnt_q);
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      edge_cnt_q <= '0;
      cnt        <= '0;
      stall      <= 1'b0;
    end else if (clr) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= (!fan_en || close) ? '0 : closing;
      if (close) begin
        cnt   <= fan_en ? closing : '0;
        stall <= fan_en && (closing == '0);
      end
    end
  end

  // per_cnt restarts at 1 on each edge so an edge N cycles later reports N.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      per_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      per          <= '0;
    end else if (!fan_en) begin
      per_cnt_q    <= '0;
      first_seen_q <= 1'b0;
      per          <= '0;
    end else if (clr) begin
      per_cnt_q    <= '0;
      first_seen_q <= 1'b0;
    end else if (edge_fall) begin
      if (first_seen_q) per <= per_cnt_q;
      per_cnt_q    <= PER_W'(1);
      first_seen_q <= 1'b1;
    end else if (!(&per_cnt_q)) begin
      per_cnt_q <= per_cnt_q + PER_W'(1);
    end
  end

endmodule

// File: rtl/fan_tach.sv
// ----------------------------------------------------------------------------
// fan_tach
// Multi-channel fan tachometer front end. Holds the shared window counter and
// the update strobe, and fans clear/close out to one fan_tach_ch per channel.
// Ports:
//   CLK_I, RST_I : clock, asynchronous active-high reset
//   FAN_IN       : raw tach pins, one per channel
//   FAN_EN       : per-channel enable
//   CLR_I        : single-cycle clear of window and accumulators
//   CNT_O        : per-channel window edge count, channel i at [27i+26:27i]
//   PER_O        : per-channel edge-to-edge period, channel i at [PER_W*i +: PER_W]
//   UPD_O        : one-cycle strobe when CNT_O/STALL_O were just updated
//   STALL_O      : per-channel stall flag from the last completed window
// ----------------------------------------------------------------------------
module fan_tach
  import fan_tach_pkg::*;
#(
  parameter int               N_FAN    = 2,
  parameter logic [CNT_W-1:0] WIN_CNT  = MM_CLK_1S_CNT,
  parameter int               FILT_LEN = 4,
  parameter int               PER_W    = 24
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  input  logic [N_FAN-1:0]       FAN_IN,
  input  logic [N_FAN-1:0]       FAN_EN,
  input  logic                   CLR_I,
  output logic [N_FAN*CNT_W-1:0] CNT_O,
  output logic [N_FAN*PER_W-1:0] PER_O,
  output logic                   UPD_O,
  output logic [N_FAN-1:0]       STALL_O
);

  logic [CNT_W-1:0] wcnt_q;
  logic             wrap;
  logic             close;

  assign wrap  = (wcnt_q == WIN_CNT);
  // A clear in the wrap cycle suppresses the close entirely.
  assign close = wrap & ~CLR_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wcnt_q <= '0;
      UPD_O  <= 1'b0;
    end else begin
      UPD_O <= close;
      if (CLR_I || wrap) wcnt_q <= '0;
      else               wcnt_q <= wcnt_q + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N_FAN; i++) begin : g_ch
    fan_tach_ch #(
      .FILT_LEN (FILT_LEN),
      .PER_W    (PER_W)
    ) u_ch (
      .CLK_I  (CLK_I),
      .RST_I  (RST_I),
      .fan_in (FAN_IN[i]),
      .fan_en (FAN_EN[i]),
      .clr    (CLR_I),
      .close  (close),
      .cnt    (CNT_O[CNT_W*i +: CNT_W]),
      .per    (PER_O[PER_W*i +: PER_W]),
      .stall  (STALL_O[i])
    );
  end

endmodule
